// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding,
// default sizing constants and the saturating counter increment.
package period_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 2**20;

    typedef enum logic [2:0] {
        WARM,
        ARM,
        HIGH,
        LOW,
        STUCK
    } state_t;

    // Increment value, holding at the all-ones code of a width-bit counter.
    // Callers widen to 64 bits going in and truncate coming out.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] top;
        top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= top) ? top : value + 64'd1;
    endfunction

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Input front end: SYNC_STAGES-deep synchronizer, warm-up suppression after
// reset, and registered one-cycle rise/fall strobes on the synchronized level.
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall,
    output logic warm_done
);

    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   s;

    assign s         = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_W'(WARM_CYCLES));

    // Shift the asynchronous input through the synchronizer chain.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the chain would collapse into a single stage.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Count out the warm-up window while a reset-time level drains through.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    // Registered edge strobes, gated off until warm-up has expired.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            s_d  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s_d  <= s;
            rise <= warm_done &  s & ~s_d;
            fall <= warm_done & ~s &  s_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Period meter top: times the high and low phases of a slow square wave in
// clk_in cycles and publishes each completed period through a valid/ack
// register interface. Define PERIOD_METER_STATS_EN to build min/max period
// tracking; otherwise meas_min/meas_max read 0.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic [CNT_W:0]   meas_period,
    output logic             meas_valid,
    output logic             overrun,
    output logic             stuck,
    output logic [CNT_W:0]   meas_min,
    output logic [CNT_W:0]   meas_max
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic             rise;
    logic             fall;
    logic             warm_done;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;
    logic [CNT_W-1:0] lcnt_q;
    logic [CNT_W-1:0] lcnt_d;
    logic [CNT_W-1:0] hcnt_inc;
    logic [CNT_W-1:0] lcnt_inc;
    logic [CNT_W:0]   period_sum;
    logic             publish;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_front (
        .clk_in   (clk_in),
        .reset    (reset),
        .sig_in   (sig_in),
        .rise     (rise),
        .fall     (fall),
        .warm_done(warm_done)
    );

    assign hcnt_inc   = CNT_W'(sat_inc(64'(hcnt_q), CNT_W));
    assign lcnt_inc   = CNT_W'(sat_inc(64'(lcnt_q), CNT_W));
    assign period_sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    assign stuck      = (state_q == STUCK);

    // State and phase counter registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= WARM;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Next-state, counter and publish decode. The detect cycle of an edge is
    // the first cycle of the new phase, so a new phase starts its counter at 1.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        publish = 1'b0;
        case (state_q)
            WARM: begin
                if (warm_done) state_d = ARM;
            end
            ARM, STUCK: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                    lcnt_d  = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    lcnt_d  = CNT_W'(1);
                end else begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc >= TIMEOUT_CNT) state_d = STUCK;
                end
            end
            LOW: begin
                if (rise) begin
                    publish = 1'b1;
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= TIMEOUT_CNT) state_d = STUCK;
                end
            end
            default: state_d = WARM;
        endcase
    end

    // Result registers and valid/ack handshake; an unacked overwrite is sticky.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            meas_high   <= '0;
            meas_low    <= '0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else if (publish) begin
            meas_high   <= hcnt_q;
            meas_low    <= lcnt_q;
            meas_period <= period_sum;
            meas_valid  <= 1'b1;
            if (meas_valid && !meas_ack) overrun <= 1'b1;
        end else if (meas_valid && meas_ack) begin
            meas_valid <= 1'b0;
        end
    end

`ifdef PERIOD_METER_STATS_EN
    // Track the smallest and largest published period since reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            meas_min <= '1;
            meas_max <= '0;
        end else if (publish) begin
            if (period_sum < meas_min) meas_min <= period_sum;
            if (period_sum > meas_max) meas_max <= period_sum;
        end
    end
`else
    assign meas_min = '0;
    assign meas_max = '0;
`endif

endmodule

// File: doc/period_meter.md
# period_meter

Measures the high time, low time and full period of a slow square wave, such as a divided clock, in cycles of the system clock. The input is synchronized, edge-detected and timed. Each completed period is published through a valid/ack register interface for the debug/MMIO side of the MIPS core. It is the reader for frequency-divider outputs and verifies divided clocks on the board.

## Interface
- CNT_W, default 32: width of the phase counters and of meas_high/meas_low.
- SYNC_STAGES, default 2: number of synchronizer flops on sig_in (minimum 2).
- TIMEOUT, default 2**20: phase length in clk_in cycles at which the input is declared stuck.
- clk_in, input, 1: the single clock; everything is on posedge clk_in.
- reset, input, 1: synchronous, active-high reset.
- sig_in, input, 1: measured square wave, asynchronous to clk_in.
- meas_ack, input, 1: consumer acknowledge; meaningful only while meas_valid=1.
- meas_high, output, CNT_W: high-phase length of the last completed period.
- meas_low, output, CNT_W: low-phase length of the last completed period.
- meas_period, output, CNT_W+1: meas_high+meas_low; cannot overflow.
- meas_valid, output, 1: a result is pending.
- overrun, output, 1: sticky; an unacknowledged result was overwritten.
- stuck, output, 1: the current phase has reached TIMEOUT.
- meas_min, output, CNT_W+1: smallest period seen (see Configuration).
- meas_max, output, CNT_W+1: largest period seen (see Configuration).

## Operation
- Front end: SYNC_STAGES flops, then a 1-cycle rise/fall detector on the synchronized signal `s`. Reset clears all synchronizer and detector flops to 0.
- Warm-up: edge detection is suppressed for SYNC_STAGES+1 cycles after reset is released. This prevents a false rise when sig_in is high at reset.
- States:
  - WARM: after the warm-up count expires, go to ARM.
  - ARM: the first rise goes to HIGH and clears both counters. A partial first period is never reported.
  - HIGH: hcnt increments each cycle. A fall goes to LOW. hcnt reaching TIMEOUT goes to STUCK.
  - LOW: lcnt increments each cycle. A rise publishes the result, clears both counters and goes to HIGH. lcnt reaching TIMEOUT goes to STUCK.
  - STUCK: stuck=1. The next rise clears stuck and the counters and goes to HIGH; nothing is published.
- Counting: the edge-detect cycle counts as the first cycle of the new phase, so a phase K clk_in cycles long yields K. Counters saturate at all-ones.
- Publish: meas_high and meas_low are loaded from hcnt and lcnt, meas_period is their sum, and meas_valid is set.
- Handshake:
  - An ack while meas_valid=1 clears meas_valid on the next cycle. An ack while meas_valid=0 is ignored.
  - Publish while meas_valid=1 without ack in the same cycle: the data is overwritten, meas_valid stays 1 and overrun is set.
  - Publish and ack in the same cycle: the new data is loaded, meas_valid stays 1 and overrun is not set.
- Reset values: state=WARM, counters 0, all meas_* 0, meas_valid=0, overrun=0, stuck=0. A reset mid-measurement discards the measurement in progress.

## Timing
- Edge at the sig_in pin to detect strobe: SYNC_STAGES+1 cycles, plus up to 1 cycle of metastability uncertainty.
- Detect cycle of the closing rise to meas_valid=1 and data visible: 1 cycle, registered.
- meas_ack high in cycle n gives meas_valid=0 in cycle n+1.
- stuck rises in the cycle after the phase count reaches TIMEOUT.
- The minimum measurable phase is 1 cycle. A same-domain input that toggles every K cycles gives meas_high=meas_low=K and meas_period=2K.

## Configuration
- `PERIOD_METER_STATS_EN` defined:
  - On each publish, meas_min and meas_max are updated with meas_period.
  - Reset values are meas_min=all-ones and meas_max=0.
  - Results discarded through STUCK are not counted.
- Not defined: meas_min and meas_max are tied to 0 and no comparator logic is built.

## Structure
- period_meter_pkg holds:
  - the state enum {WARM, ARM, HIGH, LOW, STUCK};
  - the default CNT_W and TIMEOUT constants;
  - the saturating-increment function.
- Sub-module sync_edge_detect contains the SYNC_STAGES synchronizer, the warm-up suppression and the rise/fall strobes. It is parameterized by SYNC_STAGES.

## Test plan
- Same-domain square wave toggling every 5 cycles, no acks: the first result is meas_high=5, meas_low=5, meas_period=10. The second publish sets overrun=1.
- Duty test, high for 3 cycles and low for 7, ack every result: meas_high=3, meas_low=7, meas_period=10. meas_valid clears 1 cycle after each ack and overrun stays 0.
- sig_in high through reset, then low for 4, high for 4: no result from the reset-time high level. The first result is 4/4/8.
- TIMEOUT=16, sig_in held high for 40 cycles: stuck=1 at the start of phase cycle 17, no meas_valid. The next rise clears stuck and a 6/6 wave then reports 6/6/12.
- Ack coinciding with the publish cycle of the next result: meas_valid stays 1, the new data is shown and overrun=0.
- With PERIOD_METER_STATS_EN, periods 10, 14, 8 in turn: meas_min=8 and meas_max=14. Without the macro both read 0.
